at_response_parser: RTL and testbench

- Sits directly downstream of the UART receiver, between its rx_data/rx_data_valid outputs and the receive FIFO write port.
- Forwards every received byte to the FIFO, splits the HC-05 AT response stream into CR LF terminated lines, and classifies each line as OK, ERROR or other.
- Exposes a line/response handshake to the connection FSM, which replaces its ad-hoc "\r\n" detector.
- Adds an inter-byte timeout so a silent module cannot hang the FSM.

---
 rtl/at_response_parser_pkg.sv | 28 ++
 rtl/at_idle_timer.sv | 34 +++
 rtl/at_response_parser.sv | 181 ++++++++++++++++++
 tb/tb_at_response_parser.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/at_response_parser_pkg.sv
// Shared definitions for the AT response parser.
//   state_t    : parser FSM state encoding
//   ASCII_*    : byte constants used for line splitting and classification
//   is_error_prefix : true when the captured first five bytes spell "ERROR"
package at_response_parser_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECEIVE   = 3'd1,
    GOT_CR    = 3'd2,
    LINE_DONE = 3'd3,
    TIMEOUT   = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;

  // match[0] holds the first byte of the line
  function automatic logic is_error_prefix(input logic [4:0][7:0] match);
    return (match[0] == ASCII_E) && (match[1] == ASCII_R) && (match[2] == ASCII_R) &&
           (match[3] == ASCII_O) && (match[4] == ASCII_R);
  endfunction

endpackage

// File: rtl/at_idle_timer.sv
// Inter-byte idle timer: clearable, enabled up-counter with a terminal-count flag.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : restart counting from zero (a byte arrived / parser restarted)
//   enable       : count while the parser is waiting for line content
//   expired      : count has reached TIMEOUT_CYCLES-1 while enabled
module at_idle_timer #(
  parameter int TMR_W          = 17,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + TMR_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/at_response_parser.sv
// HC-05 AT response parser between the UART receiver and the receive FIFO.
// Forwards received bytes to the FIFO, splits the stream into CR LF lines,
// classifies each line as OK / ERROR / other and times out on a silent link.
//
// Optional build macro: AT_PARSER_STRIP_CRLF_EN
//   defined   : CR and LF bytes are not written to the FIFO
//   undefined : every accepted byte is written to the FIFO
//
// Ports:
//   clock, reset          : system clock, asynchronous active-high reset
//   start                 : clear status and (re)start listening from any state
//   rx_data/rx_data_valid : byte stream from the UART receiver
//   fifo_data/fifo_wr_en  : registered copy of accepted bytes to the RFIFO
//   line_done/line_ack    : completed-line handshake with the connection FSM
//   line_len              : saturated length of the completed line
//   result_ok/result_error: classification of the completed line
//   response_done         : sticky, an OK or ERROR line was acknowledged
//   overrun               : sticky, a byte arrived while line_done was pending
//   timeout               : sticky, no byte within the idle window
//   busy                  : parser is not idle
//
// state     | meaning
// IDLE      | waiting for start, bytes dropped
// RECEIVE   | collecting line content
// GOT_CR    | CR seen, expecting LF
// LINE_DONE | line presented, waiting for line_ack
// TIMEOUT   | idle window expired, only start/reset leaves
module at_response_parser
  import at_response_parser_pkg::*;
#(
  parameter int MAX_LINE       = 32,
  parameter int LEN_W          = 6,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMR_W          = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_valid,
  output logic [7:0]       fifo_data,
  output logic             fifo_wr_en,
  output logic             line_done,
  input  logic             line_ack,
  output logic [LEN_W-1:0] line_len,
  output logic             result_ok,
  output logic             result_error,
  output logic             response_done,
  output logic             overrun,
  output logic             timeout,
  output logic             busy
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LINE);
  localparam logic [LEN_W-1:0] LEN_TWO  = LEN_W'(2);
  localparam logic [LEN_W-1:0] LEN_FIVE = LEN_W'(5);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [4:0][7:0]  match;
  logic             receiving;
  logic             byte_in;
  logic             is_cr;
  logic             is_lf;
  logic             forward;
  logic             tmr_expired;

  assign receiving = (state == RECEIVE) || (state == GOT_CR);
  // start takes priority, so a byte coinciding with it is never accepted
  assign byte_in   = rx_data_valid && receiving && !start;
  assign is_cr     = (rx_data == ASCII_CR);
  assign is_lf     = (rx_data == ASCII_LF);

`ifdef AT_PARSER_STRIP_CRLF_EN
  assign forward = byte_in && !is_cr && !is_lf;
`else
  assign forward = byte_in;
`endif

  at_idle_timer #(
    .TMR_W         (TMR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (start || byte_in),
    .enable (receiving),
    .expired(tmr_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      match         <= '0;
      fifo_data     <= '0;
      fifo_wr_en    <= 1'b0;
      line_done     <= 1'b0;
      line_len      <= '0;
      result_ok     <= 1'b0;
      result_error  <= 1'b0;
      response_done <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      fifo_wr_en <= forward;
      if (forward) fifo_data <= rx_data;

      if (start) begin
        state         <= RECEIVE;
        busy          <= 1'b1;
        len           <= '0;
        match         <= '0;
        line_done     <= 1'b0;
        line_len      <= '0;
        result_ok     <= 1'b0;
        result_error  <= 1'b0;
        response_done <= 1'b0;
        overrun       <= 1'b0;
        timeout       <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          RECEIVE, GOT_CR: begin
            if (rx_data_valid) begin
              if (is_cr) begin
                // a repeated CR is absorbed here and never counted
                state <= GOT_CR;
              end else if (is_lf && (state == GOT_CR)) begin
                if (len != '0) begin
                  state        <= LINE_DONE;
                  line_done    <= 1'b1;
                  line_len     <= len;
                  result_ok    <= (len == LEN_TWO) && (match[0] == ASCII_O) &&
                                  (match[1] == ASCII_K);
                  result_error <= (len >= LEN_FIVE) && is_error_prefix(match);
                end else begin
                  state <= RECEIVE;  // blank separator line
                end
              end else begin
                // content byte, including one that follows a lone CR
                state <= RECEIVE;
                if (len < LEN_MAX) len <= len + LEN_W'(1);
                if (len < LEN_FIVE) match[len[2:0]] <= rx_data;
              end
            end else if (tmr_expired) begin
              state   <= TIMEOUT;
              timeout <= 1'b1;
            end
          end

          LINE_DONE: begin
            if (rx_data_valid) overrun <= 1'b1;
            if (line_ack) begin
              line_done <= 1'b0;
              if (result_ok || result_error) begin
                response_done <= 1'b1;
                state         <= IDLE;
                busy          <= 1'b0;
              end else begin
                len   <= '0;
                match <= '0;
                state <= RECEIVE;
              end
            end
          end

          TIMEOUT: ;

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_at_response_parser.sv
module tb_at_response_parser;

  localparam int LEN_W = 6;
`ifdef AT_PARSER_STRIP_CRLF_EN
  localparam int CRLF_WR = 0;
`else
  localparam int CRLF_WR = 2;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_data_valid = 1'b0;
  logic             line_ack = 1'b0;
  logic [7:0]       fifo_data;
  logic             fifo_wr_en;
  logic             line_done;
  logic [LEN_W-1:0] line_len;
  logic             result_ok;
  logic             result_error;
  logic             response_done;
  logic             overrun;
  logic             timeout;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [7:0] wr_log[$];

  typedef struct {
    string txt;
    int    len;
    bit    ok;
    bit    err;
  } vec_t;

  vec_t vecs[8];

  always #5 clock = ~clock;

  at_response_parser #(
    .MAX_LINE      (32),
    .LEN_W         (LEN_W),
    .TIMEOUT_CYCLES(50),
    .TMR_W         (17)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_data_valid(rx_data_valid),
    .fifo_data    (fifo_data),
    .fifo_wr_en   (fifo_wr_en),
    .line_done    (line_done),
    .line_ack     (line_ack),
    .line_len     (line_len),
    .result_ok    (result_ok),
    .result_error (result_error),
    .response_done(response_done),
    .overrun      (overrun),
    .timeout      (timeout),
    .busy         (busy)
  );

  // FIFO write monitor: counts each cycle the strobe was high
  always @(posedge clock) begin
    if (fifo_wr_en) begin
      wr_count++;
      wr_log.push_back(fifo_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data       = b;
    rx_data_valid = 1'b1;
    @(negedge clock);
    rx_data_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic send_line(input string s, input int gap);
    send_str(s, gap);
    send_byte(8'h0D, gap);
    send_byte(8'h0A, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_ack();
    line_ack = 1'b1;
    @(negedge clock);
    line_ack = 1'b0;
  endtask

  task automatic wait_line(input string name);
    int n;
    n = 0;
    while (!line_done && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({name, "_line_done"}, int'(line_done), 1);
  endtask

  initial begin
    int base;
    int first;
    int n;

    vecs[0] = '{txt: "OK",         len: 2,  ok: 1'b1, err: 1'b0};
    vecs[1] = '{txt: "ERROR:(0)",  len: 9,  ok: 1'b0, err: 1'b1};
    vecs[2] = '{txt: "OKAY",       len: 4,  ok: 1'b0, err: 1'b0};
    vecs[3] = '{txt: "ERROR",      len: 5,  ok: 1'b0, err: 1'b1};
    vecs[4] = '{txt: "ERRO",       len: 4,  ok: 1'b0, err: 1'b0};
    vecs[5] = '{txt: "O",          len: 1,  ok: 1'b0, err: 1'b0};
    vecs[6] = '{txt: "+NAME:HC05", len: 10, ok: 1'b0, err: 1'b0};
    vecs[7] = '{txt: "KO",         len: 2,  ok: 1'b0, err: 1'b0};

    // reset state
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_line_done", int'(line_done), 0);
    check("rst_fifo_wr_en", int'(fifo_wr_en), 0);
    check("rst_line_len", int'(line_len), 0);
    check("rst_flags", int'({result_ok, result_error, response_done, overrun, timeout}), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_busy", int'(busy), 0);

    // "OK\r\n" with 30-clock spacing
    pulse_start();
    check("start_busy", int'(busy), 1);
    base  = wr_count;
    first = wr_log.size();
    send_line("OK", 30);
    wait_line("ok30");
    settle();
    check("ok30_writes", wr_count - base, 2 + CRLF_WR);
    check("ok30_byte0", int'(wr_log[first]), 8'h4F);
    check("ok30_byte1", int'(wr_log[first + 1]), 8'h4B);
    check("ok30_len", int'(line_len), 2);
    check("ok30_ok", int'(result_ok), 1);
    do_ack();
    @(negedge clock);
    check("ok30_resp_done", int'(response_done), 1);
    check("ok30_busy", int'(busy), 0);

    // table of single-line responses
    for (int i = 0; i < 8; i++) begin
      pulse_start();
      base  = wr_count;
      first = wr_log.size();
      send_line(vecs[i].txt, 1);
      wait_line($sformatf("vec%0d", i));
      settle();
      check($sformatf("vec%0d_len", i), int'(line_len), vecs[i].len);
      check($sformatf("vec%0d_ok", i), int'(result_ok), int'(vecs[i].ok));
      check($sformatf("vec%0d_err", i), int'(result_error), int'(vecs[i].err));
      check($sformatf("vec%0d_writes", i), wr_count - base, vecs[i].len + CRLF_WR);
      check($sformatf("vec%0d_first", i), int'(wr_log[first]), int'(vecs[i].txt[0]));
      do_ack();
      @(negedge clock);
      check($sformatf("vec%0d_ack_ld", i), int'(line_done), 0);
      check($sformatf("vec%0d_resp", i), int'(response_done), int'(vecs[i].ok | vecs[i].err));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(!(vecs[i].ok | vecs[i].err)));
    end

    // multi-line stream with a blank separator line
    pulse_start();
    send_line("+NAME:HC05", 0);
    wait_line("ml1");
    check("ml1_len", int'(line_len), 10);
    check("ml1_class", int'({result_ok, result_error}), 0);
    do_ack();
    send_byte(8'h0D, 0);
    send_byte(8'h0A, 0);
    settle();
    check("ml_blank_skipped", int'(line_done), 0);
    send_line("OK", 0);
    wait_line("ml2");
    check("ml2_ok", int'(result_ok), 1);
    check("ml2_resp_before_ack", int'(response_done), 0);
    do_ack();
    @(negedge clock);
    check("ml2_resp", int'(response_done), 1);

    // start wins over a simultaneous byte
    start         = 1'b1;
    rx_data       = 8'h58;
    rx_data_valid = 1'b1;
    @(negedge clock);
    start         = 1'b0;
    rx_data_valid = 1'b0;
    base = wr_count;
    send_line("OK", 0);
    wait_line("sw");
    settle();
    check("sw_len", int'(line_len), 2);
    check("sw_ok", int'(result_ok), 1);
    check("sw_writes", wr_count - base, 2 + CRLF_WR);
    do_ack();

    // overrun, ack with simultaneous byte, length saturation
    pulse_start();
    send_line("AB", 0);
    wait_line("ov");
    settle();
    base = wr_count;
    send_byte(8'h41, 1);
    settle();
    check("ov_flag", int'(overrun), 1);
    check("ov_no_write", wr_count - base, 0);
    check("ov_line_held", int'(line_done), 1);
    check("ov_len_held", int'(line_len), 2);
    line_ack      = 1'b1;
    rx_data       = 8'h42;
    rx_data_valid = 1'b1;
    @(negedge clock);
    line_ack      = 1'b0;
    rx_data_valid = 1'b0;
    settle();
    check("ackbyte_ld", int'(line_done), 0);
    check("ackbyte_no_write", wr_count - base, 0);
    check("ackbyte_busy", int'(busy), 1);
    for (int i = 0; i < 40; i++) send_byte(8'h41 + 8'(i % 26), 0);
    send_byte(8'h0D, 0);
    send_byte(8'h0A, 0);
    wait_line("sat");
    check("sat_len", int'(line_len), 32);
    check("sat_class", int'({result_ok, result_error}), 0);
    check("sat_overrun_sticky", int'(overrun), 1);
    do_ack();

    // idle timeout
    pulse_start();
    send_byte(8'h41, 0);
    send_byte(8'h42, 0);
    n = 0;
    while (!timeout && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("to_cycles", n, 50);
    check("to_busy", int'(busy), 1);
    base = wr_count;
    send_byte(8'h43, 2);
    settle();
    check("to_dropped", wr_count - base, 0);
    check("to_sticky", int'(timeout), 1);
    pulse_start();
    check("to_cleared", int'(timeout), 0);
    check("to_restart_busy", int'(busy), 1);

    // asynchronous reset mid-line
    pulse_start();
    send_str("ABC", 0);
    check("mid_wr_before_rst", int'(fifo_wr_en), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_wr", int'(fifo_wr_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(fifo_data), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pulse_start();
    send_line("OK", 0);
    wait_line("post_rst");
    check("post_rst_ok", int'(result_ok), 1);
    check("post_rst_len", int'(line_len), 2);
    do_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
